// File: rtl/program_loader_pkg.sv
// Shared constants and state encodings for the serial program loader.
// The instruction width is shared with the decoder and the instruction memory.
package program_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int INSTR_W    = 24;
  localparam int IMEM_AW    = 8;
  localparam int WORD_CNT_W = 9;

  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM
  } loader_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } uart_state_e;

endpackage

// File: rtl/program_loader_if.sv
// Instruction-memory write port driven by the program loader.
// The loader is the master; the instruction memory's write side is the slave.
interface program_loader_if;
  import program_loader_pkg::*;

  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  instr_t             imem_wdata;

  modport master (output imem_we, output imem_addr, output imem_wdata);
  modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);

endinterface

// File: rtl/program_loader_uart_rx.sv
// 8N1 UART receiver: synchronised input, mid-bit start validation, centre sampling.
// Emits one-cycle byte_valid or frame_err pulses after the stop bit is sampled.
module program_loader_uart_rx
  import program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  uart_state_e      state_q;
  logic [1:0]       rxSync_q;
  logic             rxPrev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bitIdx_q;
  logic [7:0]       shift_q;
  logic             byteValid_q;
  logic             frameErr_q;

  logic rxBit;
  assign rxBit = rxSync_q[1];

  // Synchroniser and edge history reset to the idle-high line level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RX_IDLE;
      rxSync_q    <= 2'b11;
      rxPrev_q    <= 1'b1;
      cnt_q       <= '0;
      bitIdx_q    <= '0;
      shift_q     <= '0;
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      rxSync_q    <= {rxSync_q[0], rx};
      rxPrev_q    <= rxBit;
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (rxPrev_q && !rxBit) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q    <= '0;
            bitIdx_q <= '0;
            state_q  <= rxBit ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q    <= '0;
            shift_q  <= {rxBit, shift_q[7:1]};
            bitIdx_q <= bitIdx_q + 3'd1;
            if (bitIdx_q == 3'd7) begin
              state_q <= RX_STOP;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            if (rxBit) begin
              byteValid_q <= 1'b1;
            end else begin
              frameErr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_valid = byteValid_q;
  assign byte_data  = shift_q;
  assign frame_err  = frameErr_q;

endmodule

// File: rtl/program_loader.sv
// Serial boot loader: parses SYNC/LEN/data/CSUM frames from the UART and
// writes 24-bit words into instruction memory while holding the CPU.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT   = 868,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 10_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  program_loader_if.master      imem,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_err,
  output logic [WORD_CNT_W-1:0] word_count
);

  localparam int TOUT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT_CYCLES - 1);

  logic       byteValid;
  logic [7:0] byteData;
  logic       frameErr;

  program_loader_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) uartRx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_valid (byteValid),
    .byte_data  (byteData),
    .frame_err  (frameErr)
  );

  loader_state_e         state_q;
  logic [WORD_CNT_W-1:0] len_q;
  logic [WORD_CNT_W-1:0] wordCount_q;
  logic [7:0]            csum_q;
  logic [1:0]            byteIdx_q;
  logic [15:0]           asm_q;
  logic [TOUT_W-1:0]     idleCnt_q;
  logic                  imemWe_q;
  logic [IMEM_AW-1:0]    imemAddr_q;
  instr_t                imemWdata_q;
  logic                  cpuHold_q;
  logic                  loadDone_q;
  logic                  loadErr_q;

  instr_t                assembled_d;
  logic [WORD_CNT_W-1:0] wordCount_d;
  logic                  abort;

  assign assembled_d = {asm_q, byteData};
  assign wordCount_d = wordCount_q + WORD_CNT_W'(1);

  // A framing error or a silent line mid-frame abandons the frame, keeping the CPU held.
  assign abort = (state_q != ST_IDLE) &&
                 (frameErr || (!byteValid && idleCnt_q == TOUT_LAST));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      wordCount_q <= '0;
      csum_q      <= '0;
      byteIdx_q   <= '0;
      asm_q       <= '0;
      idleCnt_q   <= '0;
      imemWe_q    <= 1'b0;
      imemAddr_q  <= '0;
      imemWdata_q <= '0;
      cpuHold_q   <= 1'b0;
      loadDone_q  <= 1'b0;
      loadErr_q   <= 1'b0;
    end else begin
      imemWe_q   <= 1'b0;
      loadDone_q <= 1'b0;
      if (state_q == ST_IDLE || byteValid) begin
        idleCnt_q <= '0;
      end else begin
        idleCnt_q <= idleCnt_q + TOUT_W'(1);
      end

      if (abort) begin
        loadErr_q <= 1'b1;
        state_q   <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (byteValid && byteData == SYNC_BYTE) begin
              cpuHold_q   <= 1'b1;
              loadErr_q   <= 1'b0;
              wordCount_q <= '0;
              csum_q      <= '0;
              byteIdx_q   <= '0;
              state_q     <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (byteValid) begin
              len_q   <= (byteData == 8'd0) ? WORD_CNT_W'(256) : {1'b0, byteData};
              state_q <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (byteValid) begin
              csum_q <= csum_q + byteData;
              asm_q  <= assembled_d[15:0];
              if (byteIdx_q == 2'd2) begin
                byteIdx_q   <= '0;
                imemWe_q    <= 1'b1;
                imemAddr_q  <= wordCount_q[IMEM_AW-1:0];
                imemWdata_q <= assembled_d;
                wordCount_q <= wordCount_d;
                if (wordCount_d == len_q) begin
                  state_q <= ST_CSUM;
                end
              end else begin
                byteIdx_q <= byteIdx_q + 2'd1;
              end
            end
          end
          ST_CSUM: begin
            if (byteValid) begin
              if (byteData == csum_q) begin
                loadDone_q <= 1'b1;
                cpuHold_q  <= 1'b0;
              end else begin
                loadErr_q <= 1'b1;
              end
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign imem.imem_we    = imemWe_q;
  assign imem.imem_addr  = imemAddr_q;
  assign imem.imem_wdata = imemWdata_q;
  assign cpu_hold        = cpuHold_q;
  assign load_done       = loadDone_q;
  assign load_err        = loadErr_q;
  assign word_count      = wordCount_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: drives UART frames on rx and logs every
// instruction-memory write and load_done pulse for comparison against hand values.
module tb_program_loader;
  import program_loader_pkg::*;

  // Short bit period keeps the 256-word frame quick.
  localparam int CPB  = 8;
  localparam int TOUT = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;
  logic [8:0] word_count;

  program_loader_if imemBus ();

  program_loader #(
    .CLKS_PER_BIT   (CPB),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .imem       (imemBus),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  logic [7:0]  wrAddrQ[$];
  logic [23:0] wrDataQ[$];
  logic [8:0]  wrCountQ[$];
  int          doneTotal      = 0;
  int          weRun          = 0;
  int          weRunMax       = 0;
  logic        prevHold       = 1'b0;
  logic        holdAtDone     = 1'b0;
  logic        holdBeforeDone = 1'b0;

  // Write/done monitor sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (imemBus.imem_we === 1'b1) begin
      wrAddrQ.push_back(imemBus.imem_addr);
      wrDataQ.push_back(imemBus.imem_wdata);
      wrCountQ.push_back(word_count);
      weRun = weRun + 1;
      if (weRun > weRunMax) weRunMax = weRun;
    end else begin
      weRun = 0;
    end
    if (load_done === 1'b1) begin
      doneTotal      = doneTotal + 1;
      holdAtDone     = cpu_hold;
      holdBeforeDone = prevHold;
    end
    prevHold = cpu_hold;
  end

  int assertCount = 0;
  int failCount   = 0;
  int wrBase;
  int doneBase;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount = assertCount + 1;
    if (observed !== expected) begin
      failCount = failCount + 1;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Sends one 8N1 byte, LSB first; entered and left on a falling edge.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stopBit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!stopBit) repeat (CPB) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [95:0] bytes, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(bytes[8*(n-1-i) +: 8], 1'b1);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic markBase();
    wrBase   = wrAddrQ.size();
    doneBase = doneTotal;
  endtask

  initial begin
    $display("[TB] reset with rx toggling");
    repeat (3) begin
      @(negedge clk);
      rx = ~rx;
    end
    checkOutput("rst_we",        {31'd0, imemBus.imem_we}, 32'd0);
    checkOutput("rst_addr",      {24'd0, imemBus.imem_addr}, 32'd0);
    checkOutput("rst_wdata",     {8'd0, imemBus.imem_wdata}, 32'd0);
    checkOutput("rst_hold",      {31'd0, cpu_hold}, 32'd0);
    checkOutput("rst_done",      {31'd0, load_done}, 32'd0);
    checkOutput("rst_err",       {31'd0, load_err}, 32'd0);
    checkOutput("rst_wcount",    {23'd0, word_count}, 32'd0);
    checkOutput("rst_no_writes", wrAddrQ.size(), 32'd0);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] good two-word frame");
    markBase();
    sendFrame(96'hA5_02_11_22_33_44_55_66_65, 9);
    checkOutput("good_nwrites",   wrAddrQ.size() - wrBase, 32'd2);
    checkOutput("good_addr0",     {24'd0, wrAddrQ[wrBase]}, 32'd0);
    checkOutput("good_data0",     {8'd0, wrDataQ[wrBase]}, 32'h112233);
    checkOutput("good_wc_at_wr0", {23'd0, wrCountQ[wrBase]}, 32'd1);
    checkOutput("good_addr1",     {24'd0, wrAddrQ[wrBase+1]}, 32'd1);
    checkOutput("good_data1",     {8'd0, wrDataQ[wrBase+1]}, 32'h445566);
    checkOutput("good_wcount",    {23'd0, word_count}, 32'd2);
    checkOutput("good_ndone",     doneTotal - doneBase, 32'd1);
    checkOutput("good_hold_pre",  {31'd0, holdBeforeDone}, 32'd1);
    checkOutput("good_hold_done", {31'd0, holdAtDone}, 32'd0);
    checkOutput("good_err",       {31'd0, load_err}, 32'd0);
    checkOutput("good_we_width",  weRunMax, 32'd1);

    $display("[TB] bad checksum then recovery");
    markBase();
    sendFrame(96'hA5_02_11_22_33_44_55_66_00, 9);
    checkOutput("badcs_nwrites", wrAddrQ.size() - wrBase, 32'd2);
    checkOutput("badcs_err",     {31'd0, load_err}, 32'd1);
    checkOutput("badcs_hold",    {31'd0, cpu_hold}, 32'd1);
    checkOutput("badcs_ndone",   doneTotal - doneBase, 32'd0);
    markBase();
    sendFrame(96'hA5_02_11_22_33_44_55_66_65, 9);
    checkOutput("recov_err",   {31'd0, load_err}, 32'd0);
    checkOutput("recov_hold",  {31'd0, cpu_hold}, 32'd0);
    checkOutput("recov_ndone", doneTotal - doneBase, 32'd1);

    $display("[TB] idle noise, then sync value inside data");
    markBase();
    sendFrame(96'h3C_5A, 2);
    checkOutput("noise_hold",    {31'd0, cpu_hold}, 32'd0);
    checkOutput("noise_wcount",  {23'd0, word_count}, 32'd2);
    checkOutput("noise_nwrites", wrAddrQ.size() - wrBase, 32'd0);
    sendFrame(96'hA5_01_A5_00_01_A6, 6);
    checkOutput("midsync_nwrites", wrAddrQ.size() - wrBase, 32'd1);
    checkOutput("midsync_addr",    {24'd0, wrAddrQ[wrBase]}, 32'd0);
    checkOutput("midsync_data",    {8'd0, wrDataQ[wrBase]}, 32'hA50001);
    checkOutput("midsync_ndone",   doneTotal - doneBase, 32'd1);
    checkOutput("midsync_wcount",  {23'd0, word_count}, 32'd1);

    $display("[TB] LEN=0 full 256-word image");
    markBase();
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h00, 1'b1);
    for (int i = 0; i < 768; i++) applyStimulus(8'h01, 1'b1);
    applyStimulus(8'h00, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("full_nwrites",   wrAddrQ.size() - wrBase, 32'd256);
    checkOutput("full_first_adr", {24'd0, wrAddrQ[wrBase]}, 32'd0);
    checkOutput("full_last_adr",  {24'd0, wrAddrQ[wrAddrQ.size()-1]}, 32'hFF);
    checkOutput("full_last_data", {8'd0, wrDataQ[wrDataQ.size()-1]}, 32'h010101);
    checkOutput("full_last_wc",   {23'd0, wrCountQ[wrCountQ.size()-1]}, 32'd256);
    checkOutput("full_wcount",    {23'd0, word_count}, 32'd256);
    checkOutput("full_ndone",     doneTotal - doneBase, 32'd1);
    checkOutput("full_err",       {31'd0, load_err}, 32'd0);

    $display("[TB] timeout abort");
    markBase();
    sendFrame(96'hA5_02_11_22, 4);
    repeat (1850) @(negedge clk);
    checkOutput("tout_early_err",  {31'd0, load_err}, 32'd0);
    checkOutput("tout_early_hold", {31'd0, cpu_hold}, 32'd1);
    repeat (250) @(negedge clk);
    checkOutput("tout_err",     {31'd0, load_err}, 32'd1);
    checkOutput("tout_hold",    {31'd0, cpu_hold}, 32'd1);
    checkOutput("tout_nwrites", wrAddrQ.size() - wrBase, 32'd0);
    sendFrame(96'hA5_01_00_00_07_07, 6);
    checkOutput("tout_idle_ndone", doneTotal - doneBase, 32'd1);
    checkOutput("tout_idle_data",  {8'd0, wrDataQ[wrBase]}, 32'h000007);
    checkOutput("tout_idle_err",   {31'd0, load_err}, 32'd0);

    $display("[TB] framing error abort");
    markBase();
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h02, 1'b1);
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    applyStimulus(8'h33, 1'b1);
    applyStimulus(8'h44, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("ferr_err",     {31'd0, load_err}, 32'd1);
    checkOutput("ferr_hold",    {31'd0, cpu_hold}, 32'd1);
    checkOutput("ferr_nwrites", wrAddrQ.size() - wrBase, 32'd1);
    sendFrame(96'h55_66, 2);
    checkOutput("ferr_after_nwrites", wrAddrQ.size() - wrBase, 32'd1);
    checkOutput("ferr_after_ndone",   doneTotal - doneBase, 32'd0);

    $display("[TB] reset mid-frame");
    markBase();
    sendFrame(96'hA5_02_11_22_33, 5);
    checkOutput("mrst_pre_hold", {31'd0, cpu_hold}, 32'd1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mrst_we",     {31'd0, imemBus.imem_we}, 32'd0);
    checkOutput("mrst_addr",   {24'd0, imemBus.imem_addr}, 32'd0);
    checkOutput("mrst_wdata",  {8'd0, imemBus.imem_wdata}, 32'd0);
    checkOutput("mrst_hold",   {31'd0, cpu_hold}, 32'd0);
    checkOutput("mrst_err",    {31'd0, load_err}, 32'd0);
    checkOutput("mrst_wcount", {23'd0, word_count}, 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    markBase();
    sendFrame(96'h44_55_66, 3);
    checkOutput("mrst_after_nwrites", wrAddrQ.size() - wrBase, 32'd0);
    checkOutput("mrst_after_hold",    {31'd0, cpu_hold}, 32'd0);
    checkOutput("mrst_after_ndone",   doneTotal - doneBase, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
